// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
// Walks a KSIZE x KSIZE window over an image in raster order, one window
// per valid/ready handshake, and brackets the layer with start/stop pulses
// for the PE dataflow controller.
//
// Ports
//   CONV_WINDOW_SCHEDULER_Clk / _Reset_InLow    clock, async active-low reset
//   _Start, _Abort                             layer control
//   _Img_Width, _Img_Height, _Stride           config, latched at accepted start
//   _Win_Ready                                 PE accepts current window
//   _Pe_Start_Routine, _Pe_Stop_Routine        one-cycle PE pulses
//   _Win_Valid, _Win_Row, _Win_Col, _Win_Last  current window
//   _Win_Count                                 windows accepted this layer
//   _Busy, _Done, _Cfg_Error                   status
//
// state | meaning
// IDLE  | waiting for start; cfg_error may be held from a rejected start
// ARM   | pe_start pulse, busy raised
// RUN   | presenting windows, advancing on handshake
// STOP  | pe_stop pulse (normal end or abort)
// DONE  | done pulse, busy low; skipped after an abort
module conv_window_scheduler #(
    parameter int CNT_W = 8,
    parameter int KSIZE = 3
) (
    input  logic                 CONV_WINDOW_SCHEDULER_Clk,
    input  logic                 CONV_WINDOW_SCHEDULER_Reset_InLow,
    input  logic                 CONV_WINDOW_SCHEDULER_Start,
    input  logic                 CONV_WINDOW_SCHEDULER_Abort,
    input  logic [CNT_W-1:0]     CONV_WINDOW_SCHEDULER_Img_Width,
    input  logic [CNT_W-1:0]     CONV_WINDOW_SCHEDULER_Img_Height,
    input  logic [1:0]           CONV_WINDOW_SCHEDULER_Stride,
    input  logic                 CONV_WINDOW_SCHEDULER_Win_Ready,
    output logic                 CONV_WINDOW_SCHEDULER_Pe_Start_Routine,
    output logic                 CONV_WINDOW_SCHEDULER_Pe_Stop_Routine,
    output logic                 CONV_WINDOW_SCHEDULER_Win_Valid,
    output logic [CNT_W-1:0]     CONV_WINDOW_SCHEDULER_Win_Row,
    output logic [CNT_W-1:0]     CONV_WINDOW_SCHEDULER_Win_Col,
    output logic                 CONV_WINDOW_SCHEDULER_Win_Last,
    output logic [2*CNT_W-1:0]   CONV_WINDOW_SCHEDULER_Win_Count,
    output logic                 CONV_WINDOW_SCHEDULER_Busy,
    output logic                 CONV_WINDOW_SCHEDULER_Done,
    output logic                 CONV_WINDOW_SCHEDULER_Cfg_Error
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_STOP, S_DONE} state_t;

    localparam logic [CNT_W:0]     K_EXT   = (CNT_W+1)'(KSIZE);
    localparam logic [2*CNT_W-1:0] CNT_ONE = {{(2*CNT_W-1){1'b0}}, 1'b1};

    state_t               state;
    logic [CNT_W-1:0]     width_q, height_q, row_q, col_q;
    logic [1:0]           stride_q;
    logic [2*CNT_W-1:0]   count_q;
    logic                 aborted_q, pe_start_q, pe_stop_q, valid_q, last_q;
    logic                 busy_q, done_q, cfg_err_q;

    logic [CNT_W:0]       s_ext, col_lim, row_lim, col_step, row_step;
    logic [CNT_W-1:0]     nxt_row, nxt_col;
    logic                 col_wrap, nxt_last, first_last, cfg_bad;

    // All coordinate arithmetic is one bit wider than the coordinates so
    // that col+stride never wraps on a maximum-size image.
    always_comb begin
        s_ext      = {{(CNT_W-1){1'b0}}, stride_q};
        col_lim    = {1'b0, width_q}  - K_EXT;
        row_lim    = {1'b0, height_q} - K_EXT;
        col_step   = {1'b0, col_q} + s_ext;
        row_step   = {1'b0, row_q} + s_ext;
        col_wrap   = col_step > col_lim;
        nxt_col    = col_wrap ? '0 : col_step[CNT_W-1:0];
        nxt_row    = col_wrap ? row_step[CNT_W-1:0] : row_q;
        nxt_last   = (({1'b0, nxt_col} + s_ext) > col_lim) &&
                     (({1'b0, nxt_row} + s_ext) > row_lim);
        first_last = (s_ext > col_lim) && (s_ext > row_lim);
        cfg_bad    = ({1'b0, CONV_WINDOW_SCHEDULER_Img_Width}  < K_EXT) ||
                     ({1'b0, CONV_WINDOW_SCHEDULER_Img_Height} < K_EXT);
    end

    always_ff @(posedge CONV_WINDOW_SCHEDULER_Clk or negedge CONV_WINDOW_SCHEDULER_Reset_InLow) begin
        if (!CONV_WINDOW_SCHEDULER_Reset_InLow) begin
            state      <= S_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            stride_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            count_q    <= '0;
            aborted_q  <= 1'b0;
            pe_start_q <= 1'b0;
            pe_stop_q  <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            pe_start_q <= 1'b0;
            pe_stop_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (CONV_WINDOW_SCHEDULER_Start) begin
                        width_q   <= CONV_WINDOW_SCHEDULER_Img_Width;
                        height_q  <= CONV_WINDOW_SCHEDULER_Img_Height;
                        stride_q  <= (CONV_WINDOW_SCHEDULER_Stride == 2'd0) ? 2'd1
                                                                            : CONV_WINDOW_SCHEDULER_Stride;
                        count_q   <= '0;
                        aborted_q <= 1'b0;
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            cfg_err_q  <= 1'b0;
                            pe_start_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state      <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    if (CONV_WINDOW_SCHEDULER_Abort) begin
                        aborted_q <= 1'b1;
                        pe_stop_q <= 1'b1;
                        state     <= S_STOP;
                    end else begin
                        row_q   <= '0;
                        col_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= first_last;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort takes priority over a coincident handshake.
                    if (CONV_WINDOW_SCHEDULER_Abort) begin
                        aborted_q <= 1'b1;
                        valid_q   <= 1'b0;
                        last_q    <= 1'b0;
                        pe_stop_q <= 1'b1;
                        state     <= S_STOP;
                    end else if (CONV_WINDOW_SCHEDULER_Win_Ready) begin
                        count_q <= count_q + CNT_ONE;
                        if (last_q) begin
                            valid_q   <= 1'b0;
                            last_q    <= 1'b0;
                            pe_stop_q <= 1'b1;
                            state     <= S_STOP;
                        end else begin
                            row_q  <= nxt_row;
                            col_q  <= nxt_col;
                            last_q <= nxt_last;
                        end
                    end
                end
                S_STOP: begin
                    busy_q <= 1'b0;
                    if (aborted_q) begin
                        state <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign CONV_WINDOW_SCHEDULER_Pe_Start_Routine = pe_start_q;
    assign CONV_WINDOW_SCHEDULER_Pe_Stop_Routine  = pe_stop_q;
    assign CONV_WINDOW_SCHEDULER_Win_Valid        = valid_q;
    assign CONV_WINDOW_SCHEDULER_Win_Row          = row_q;
    assign CONV_WINDOW_SCHEDULER_Win_Col          = col_q;
    assign CONV_WINDOW_SCHEDULER_Win_Last         = last_q;
    assign CONV_WINDOW_SCHEDULER_Win_Count        = count_q;
    assign CONV_WINDOW_SCHEDULER_Busy             = busy_q;
    assign CONV_WINDOW_SCHEDULER_Done             = done_q;
    assign CONV_WINDOW_SCHEDULER_Cfg_Error        = cfg_err_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Testbench for conv_window_scheduler: expected windows are queued before
// each layer and a negedge monitor pops one per handshake.
module tb_conv_window_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  w = '0;
    logic [7:0]  h = '0;
    logic [1:0]  s = '0;
    logic        pe_start, pe_stop, valid, last, busy, done, cfg_err;
    logic [7:0]  row, col;
    logic [15:0] count;

    conv_window_scheduler #(.CNT_W(8), .KSIZE(3)) dut (
        .CONV_WINDOW_SCHEDULER_Clk              (clk),
        .CONV_WINDOW_SCHEDULER_Reset_InLow      (rst_n),
        .CONV_WINDOW_SCHEDULER_Start            (start),
        .CONV_WINDOW_SCHEDULER_Abort            (abort),
        .CONV_WINDOW_SCHEDULER_Img_Width        (w),
        .CONV_WINDOW_SCHEDULER_Img_Height       (h),
        .CONV_WINDOW_SCHEDULER_Stride           (s),
        .CONV_WINDOW_SCHEDULER_Win_Ready        (ready),
        .CONV_WINDOW_SCHEDULER_Pe_Start_Routine (pe_start),
        .CONV_WINDOW_SCHEDULER_Pe_Stop_Routine  (pe_stop),
        .CONV_WINDOW_SCHEDULER_Win_Valid        (valid),
        .CONV_WINDOW_SCHEDULER_Win_Row          (row),
        .CONV_WINDOW_SCHEDULER_Win_Col          (col),
        .CONV_WINDOW_SCHEDULER_Win_Last         (last),
        .CONV_WINDOW_SCHEDULER_Win_Count        (count),
        .CONV_WINDOW_SCHEDULER_Busy             (busy),
        .CONV_WINDOW_SCHEDULER_Done             (done),
        .CONV_WINDOW_SCHEDULER_Cfg_Error        (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] c;
        logic       l;
    } win_t;

    win_t exp_q[$];
    win_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change at posedge+1, so at negedge they show exactly what the
    // next rising edge will sample.
    always @(negedge clk) begin
        if (rst_n && valid && ready && !abort) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_window: got (%0d,%0d) expected none", row, col);
            end else begin
                mon_e = exp_q.pop_front();
                if ({row, col, last} !== {mon_e.r, mon_e.c, mon_e.l}) begin
                    errors++;
                    $display("FAIL window: got (%0d,%0d,last=%0b) expected (%0d,%0d,last=%0b)",
                             row, col, last, mon_e.r, mon_e.c, mon_e.l);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_layer(input int iw, input int ih, input int is);
        int se;
        se = (is == 0) ? 1 : is;
        for (int r = 0; r <= ih - 3; r += se)
            for (int c = 0; c <= iw - 3; c += se)
                exp_q.push_back({8'(r), 8'(c), 1'((r + se > ih - 3) && (c + se > iw - 3))});
    endtask

    // Full layer with ready high, optionally a 4-cycle stall at (1,1) and a
    // start poke with a bad width while running (must be ignored).
    task automatic run_layer(input int iw, input int ih, input int is, input int exp_n,
                             input bit stall, input bit poke);
        int cyc, n_start, n_stop, n_done, t_start, t_stop, t_done, both, rem;
        bit stalled;
        logic [15:0] held;
        n_start = 0; n_stop = 0; n_done = 0; both = 0; rem = 0; stalled = 0;
        t_start = -1; t_stop = -1; t_done = -1; held = '0;
        push_layer(iw, ih, is);
        ready = 1'b1;
        w = 8'(iw); h = 8'(ih); s = 2'(is);
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc < exp_n + 30 && n_done == 0) begin
            if (pe_start) begin n_start++; t_start = cyc; end
            if (pe_stop)  begin n_stop++;  t_stop  = cyc; end
            if (pe_start && pe_stop) both++;
            if (cyc == 1) begin
                check("arm_busy", busy, 1);
                check("arm_cfg_error", cfg_err, 0);
            end
            if (done) begin
                n_done++; t_done = cyc;
                check("done_count", count, exp_n);
                check("done_busy", busy, 0);
                check("done_cfg_error", cfg_err, 0);
            end
            if (rem > 0) begin
                check("stall_row", row, 1);
                check("stall_col", col, 1);
                check("stall_valid", valid, 1);
                check("stall_count", count, held);
                rem--;
                if (rem == 0) ready = 1'b1;
            end else if (stall && !stalled && valid && row == 8'd1 && col == 8'd1) begin
                check("stall_entry_count", count, 4);
                held = count;
                ready = 1'b0;
                rem = 4;
                stalled = 1'b1;
            end
            if (poke && cyc == 4) begin
                start = 1'b1; w = 8'd2;
            end else if (poke && cyc == 5) begin
                start = 1'b0;
            end
            step();
            cyc++;
        end
        check("pe_start_pulses", n_start, 1);
        check("pe_start_cycle", t_start, 1);
        check("pe_stop_pulses", n_stop, 1);
        check("pe_stop_cycle", t_stop, exp_n + 2 + (stall ? 4 : 0));
        check("done_pulses", n_done, 1);
        check("done_cycle", t_done, t_stop + 1);
        check("pulse_overlap", both, 0);
        check("queue_drained", exp_q.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_valid", valid, 0);
    endtask

    initial begin
        int n_stop, n_done;
        bit fired;

        // reset state
        step();
        check("reset_outputs", {pe_start, pe_stop, valid, row, col, last, count, busy, done, cfg_err}, 0);
        rst_n = 1'b1;
        step();
        check("post_reset_outputs", {pe_start, pe_stop, valid, row, col, last, count, busy, done, cfg_err}, 0);

        run_layer(5, 5, 1, 9, 0, 0);
        run_layer(7, 7, 2, 9, 0, 1);
        run_layer(5, 5, 0, 9, 0, 0);
        run_layer(5, 5, 1, 9, 1, 0);

        // undersized image rejected, sticky until next good start
        w = 8'd2; h = 8'd5; s = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        check("cfg_error_set", cfg_err, 1);
        check("cfg_error_busy", busy, 0);
        check("cfg_error_no_pe_start", pe_start, 0);
        step(); step(); step();
        check("cfg_error_sticky", cfg_err, 1);
        check("cfg_error_idle", {pe_start, busy, valid}, 0);
        run_layer(5, 5, 1, 9, 0, 0);

        // abort with ready high at the 4th window
        push_layer(5, 5, 1);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        ready = 1'b1; w = 8'd5; h = 8'd5; s = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        n_stop = 0; n_done = 0; fired = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pe_stop) n_stop++;
            if (done) n_done++;
            if (abort) begin
                abort = 1'b0;
                check("abort_pe_stop", pe_stop, 1);
                check("abort_valid", valid, 0);
            end else if (!fired && valid && count == 16'd3) begin
                abort = 1'b1;
                fired = 1'b1;
            end
            step();
        end
        check("abort_fired", fired, 1);
        check("abort_count", count, 3);
        check("abort_stop_pulses", n_stop, 1);
        check("abort_no_done", n_done, 0);
        check("abort_busy", busy, 0);
        check("abort_queue", exp_q.size(), 0);

        // abort while arming
        ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("arm_abort_pe_start", pe_start, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("arm_abort_stop", {pe_start, pe_stop, valid}, 3'b010);
        step();
        check("arm_abort_idle", {busy, done, pe_stop}, 0);
        step();
        check("arm_abort_no_done", done, 0);

        // reset in the middle of a layer
        ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check("pre_reset_valid", valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {pe_start, pe_stop, valid, row, col, last, count, busy, done, cfg_err}, 0);
        step(); step();
        check("reset_held_outputs", {pe_start, pe_stop, valid, busy, done}, 0);
        rst_n = 1'b1;
        step();
        run_layer(5, 5, 1, 9, 0, 0);

        // largest image
        run_layer(255, 255, 1, 64009, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_scheduler.md
CONV_WINDOW_SCHEDULER -- requirements
Module: conv_window_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning coordinate/size width in bits.
REQ-002 SHALL have parameter KSIZE, default 3, meaning square kernel edge in pixels.
REQ-003 CONV_WINDOW_SCHEDULER_Clk  in  1  single clock; all state changes on rising edge.
REQ-004 CONV_WINDOW_SCHEDULER_Reset_InLow  in  1  reset, asynchronous, active-low.
REQ-005 CONV_WINDOW_SCHEDULER_Start  in  1  start-of-layer request, sampled only in IDLE.
REQ-006 CONV_WINDOW_SCHEDULER_Abort  in  1  synchronous abort of a running layer.
REQ-007 CONV_WINDOW_SCHEDULER_Img_Width  in  CNT_W  image width in pixels, latched at accepted Start.
REQ-008 CONV_WINDOW_SCHEDULER_Img_Height  in  CNT_W  image height in pixels, latched at accepted Start.
REQ-009 CONV_WINDOW_SCHEDULER_Stride  in  2  window stride, latched at accepted Start.
REQ-010 CONV_WINDOW_SCHEDULER_Win_Ready  in  1  PE datapath accepts current window.
REQ-011 CONV_WINDOW_SCHEDULER_Pe_Start_Routine  out  1  start pulse to PE dataflow controller.
REQ-012 CONV_WINDOW_SCHEDULER_Pe_Stop_Routine  out  1  stop pulse to PE dataflow controller.
REQ-013 CONV_WINDOW_SCHEDULER_Win_Valid  out  1  window coordinates valid.
REQ-014 CONV_WINDOW_SCHEDULER_Win_Row / _Win_Col  out  CNT_W each  top-left window coordinate.
REQ-015 CONV_WINDOW_SCHEDULER_Win_Last  out  1  current window is the final one.
REQ-016 CONV_WINDOW_SCHEDULER_Win_Count  out  2*CNT_W  accepted windows this layer.
REQ-017 CONV_WINDOW_SCHEDULER_Busy / _Done / _Cfg_Error  out  1 each  status.

Function
REQ-018 SHALL implement states IDLE, ARM, RUN, STOP, DONE; all outputs registered.
REQ-019 IDLE + Start: latch config; Stride 0 SHALL be treated as 1; clear Win_Count, Cfg_Error.
REQ-020 If latched Width < KSIZE or Height < KSIZE: SHALL set Cfg_Error (sticky until next accepted Start), remain IDLE, emit no PE pulses.
REQ-021 Otherwise SHALL enter ARM: Pe_Start_Routine high exactly one cycle, Busy high; next cycle RUN.
REQ-022 RUN: Win_Valid high, Row/Col start at (0,0); coordinates SHALL hold stable while Win_Valid && !Win_Ready.
REQ-023 Handshake = Win_Valid && Win_Ready on a rising edge; each SHALL increment Win_Count by 1.
REQ-024 Advance: if Col+Stride <= Width-KSIZE then Col += Stride, else Col = 0 and Row += Stride; comparisons in CNT_W+1 bits, no wrap-around.
REQ-025 Win_Last SHALL be high when Col+Stride > Width-KSIZE and Row+Stride > Height-KSIZE.
REQ-026 Handshake with Win_Last: Win_Valid drops next cycle; STOP asserts Pe_Stop_Routine one cycle; then DONE asserts Done one cycle, Busy low in DONE; then IDLE.
REQ-027 Abort in ARM or RUN SHALL go to STOP (one Pe_Stop_Routine pulse) then IDLE; Done SHALL NOT pulse; Win_Count holds.
REQ-028 Abort and handshake same edge: Abort wins; handshake not counted.
REQ-029 Start while not IDLE SHALL be ignored; Abort in IDLE/STOP/DONE ignored.
REQ-030 Pe_Start_Routine and Pe_Stop_Routine SHALL never be high simultaneously; each held a full clock period for negedge sampling by the PE controller.

Reset
REQ-031 Reset_InLow low SHALL immediately force IDLE and all outputs, coordinates, Win_Count and latched config to 0, including mid-layer; no Pe_Stop_Routine pulse issued.
REQ-032 After reset release, first accepted Start SHALL behave identically to a power-on layer.

Verification
REQ-033 5x5, stride 1, Win_Ready=1 -> Pe_Start cycle 1; 9 windows (0,0)(0,1)(0,2)(1,0)...(2,2) on cycles 2-10; Win_Last on (2,2); Pe_Stop cycle 11; Done cycle 12; Win_Count=9.
REQ-034 7x7, stride 2 -> windows at rows/cols {0,2,4}, Win_Count=9; stride input 0 on 5x5 -> identical to stride 1.
REQ-035 Win_Ready low 4 cycles at (1,1) -> Row/Col=(1,1), Win_Valid high throughout, Win_Count unchanged.
REQ-036 Width=2, Start -> Cfg_Error=1, Busy=0, no Pe_Start; next valid Start clears Cfg_Error.
REQ-037 Abort with Win_Ready at window 4 -> Win_Count=3, one Pe_Stop, no Done; reset asserted mid-RUN -> all outputs 0 asynchronously.
REQ-038 255x255, stride 1 -> 64009 windows, last (252,252), no coordinate or count overflow.
